mem_ctrl: RTL

Two-port arbiter and access sequencer for the 16 x 8 program RAM. It shares the RAM between the CPU (fetch and execute) and the front-panel/loader programmer. It generates the RAM's ABUS, nWE, nCE and CS with an address-setup / strobe / recovery sequence so that the level-sensitive RAM never sees an address or data change while a strobe is active. It exposes a split data bus (dout/dout_oe/din); the top level builds the DBUS tristate.

---
 rtl/mem_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// Arbiter and access sequencer sharing the 16x8 program RAM between the CPU and the programmer.
// Each access runs SETUP -> STROBE -> RECOVER so address and data are stable around every strobe.
module mem_ctrl #(
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [3:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ack,
  input  logic       prg_req,
  input  logic       prg_we,
  input  logic [3:0] prg_addr,
  input  logic [7:0] prg_wdata,
  output logic       prg_ack,
  output logic [7:0] rdata,
  output logic       busy,
  output logic [1:0] grant,
  output logic [3:0] ABUS,
  output logic       nWE,
  output logic       nCE,
  output logic       CS,
  output logic [7:0] dout,
  output logic       dout_oe,
  input  logic [7:0] din
);

  localparam int unsigned AC_EFF = (ACCESS_CYCLES == 0) ? 1 :
                                   (ACCESS_CYCLES > 8)  ? 8 : ACCESS_CYCLES;
  localparam logic [2:0] CNT_INIT = 3'(AC_EFF - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_RECOVER} state_t;

  state_t     r_state, w_next;
  logic [2:0] r_cnt;
  logic [3:0] r_addr;
  logic       r_we;
  logic [7:0] r_wdata;
  logic [7:0] r_rdata;
  logic [1:0] r_owner;
  logic [1:0] r_mask;
  logic       r_last_cpu;

  logic w_elig_cpu, w_elig_prg, w_pick_cpu, w_pick_prg, w_strobe_done;

  // The owner is masked for one IDLE cycle so its still-high request cannot re-trigger.
  assign w_elig_cpu    = cpu_req & ~r_mask[0];
  assign w_elig_prg    = prg_req & ~r_mask[1];
  assign w_pick_cpu    = w_elig_cpu & (~w_elig_prg | ~r_last_cpu);
  assign w_pick_prg    = w_elig_prg & ~w_pick_cpu;
  assign w_strobe_done = (r_state == S_STROBE) && (r_cnt == '0);

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_pick_cpu || w_pick_prg) w_next = S_SETUP;
      S_SETUP:   w_next = S_STROBE;
      S_STROBE:  if (w_strobe_done) w_next = S_RECOVER;
      S_RECOVER: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_owner    <= '0;
      r_mask     <= '0;
      r_last_cpu <= 1'b0;
    end else begin
      r_mask <= (r_state == S_RECOVER) ? r_owner : '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_pick_cpu) begin
            r_addr     <= cpu_addr;
            r_we       <= cpu_we;
            r_wdata    <= cpu_wdata;
            r_owner    <= 2'b01;
            r_last_cpu <= 1'b1;
          end else if (w_pick_prg) begin
            r_addr     <= prg_addr;
            r_we       <= prg_we;
            r_wdata    <= prg_wdata;
            r_owner    <= 2'b10;
            r_last_cpu <= 1'b0;
          end
        end
        S_SETUP: r_cnt <= CNT_INIT;
        S_STROBE: begin
          if (r_cnt == '0) begin
            if (!r_we) r_rdata <= din;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // ABUS follows the latched address only, so it moves solely at the grant edge.
  assign ABUS  = r_addr;
  assign rdata = r_rdata;

  always_comb begin
    busy    = (r_state != S_IDLE);
    CS      = busy;
    grant   = busy ? r_owner : '0;
    nWE     = 1'b1;
    nCE     = 1'b1;
    dout_oe = 1'b0;
    dout    = '0;
    cpu_ack = 1'b0;
    prg_ack = 1'b0;
    if (busy && r_we) begin
      dout_oe = 1'b1;
      dout    = r_wdata;
    end
    if (r_state == S_STROBE) begin
      nWE = ~r_we;
      nCE = r_we;
    end
    if (r_state == S_RECOVER) begin
      cpu_ack = r_owner[0];
      prg_ack = r_owner[1];
    end
  end

endmodule
